// File: rtl/compander_arb_pkg.sv
// -----------------------------------------------------------------------------
// compander_arb_pkg
//   Shared types and helpers for the compander arbiter.
//   - ch_w()    : channel-index width for a given channel count (min 1 bit)
//   - tag_t     : {valid, channel} record carried alongside a sample in flight
//   - pick_t    : {found, index} result of a round-robin search
//   - rr_pick() : first set request at or after ptr, modulo n
// -----------------------------------------------------------------------------
package compander_arb_pkg;

   localparam int MAX_CH   = 16;
   localparam int MAX_CH_W = 4;

   function automatic int ch_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic                valid;
      logic [MAX_CH_W-1:0] channel;
   } tag_t;

   typedef struct packed {
      logic                found;
      logic [MAX_CH_W-1:0] index;
   } pick_t;

   // Scans n requesters starting at ptr and wrapping at n; the first hit wins.
   function automatic pick_t rr_pick(input logic [MAX_CH-1:0]   req,
                                     input logic [MAX_CH_W-1:0] ptr,
                                     input int                  n);
      pick_t               res;
      int                  idx;
      logic [MAX_CH_W-1:0] sel;
      res = '0;
      for (int k = 0; k < MAX_CH; k++) begin
         if (k < n && !res.found) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            sel = idx[MAX_CH_W-1:0];
            if (req[sel]) begin
               res.found = 1'b1;
               res.index = sel;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/compander_arb_fifo.sv
// -----------------------------------------------------------------------------
// compander_arb_fifo
//   Shift-register FIFO whose head entry is always storage slot 0, so the
//   data and valid outputs come straight from flops.
//   Ports:
//     clk_i, rst_i : clock, synchronous active-high reset
//     push_i/din_i : write request and data (ignored when no room is left)
//     pop_i        : read request (ignored when empty)
//     dout_o       : head entry (registered)
//     vld_o        : head entry valid (registered)
//     cnt_o        : number of stored entries
// -----------------------------------------------------------------------------
module compander_arb_fifo
   import compander_arb_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int WIDTH = 18,
   parameter int CNT_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             vld_o,
   output logic [CNT_W-1:0] cnt_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             vld_q;
   logic             do_pop, do_push;

   // Pop shifts everything toward slot 0 first; the push then lands in the
   // first free slot of the post-pop image, which makes push+pop when full
   // legal.
   always_comb begin
      mem_d  = mem_q;
      cnt_d  = cnt_q;
      do_pop = pop_i && vld_q;
      if (do_pop) begin
         for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
         cnt_d = cnt_q - CNT_W'(1);
      end
      do_push = push_i && (cnt_d < CNT_W'(DEPTH));
      if (do_push) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == cnt_d) mem_d[i] = din_i;
         end
         cnt_d = cnt_d + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         vld_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
         vld_q <= (cnt_d != '0);
         mem_q <= mem_d;
      end
   end

   assign dout_o = mem_q[0];
   assign vld_o  = vld_q;
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/compander_arbiter.sv
// -----------------------------------------------------------------------------
// compander_arbiter
//   Time-shares one compander between NR_CHANNELS sample streams. Each channel
//   has a one-deep holding register; full holders are granted round-robin (at
//   most one issue per cycle) only while the output FIFO has a free credit,
//   because the compander cannot be stalled. A {valid, channel} tag pipeline
//   matched to the compander latency re-tags each result before it enters the
//   output FIFO.
//
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     s_cmpndr_d/dv/dr         : per-channel sample input (valid/ready)
//     c_cmpndr_d/dv            : sample to the compander (unregistered)
//     c_cmpndr_q/qv            : result from the compander
//     m_cmpndr_d/ch/dv/dr      : tagged result output (valid/ready, registered)
//     err                      : sticky, compander valid disagreed with the tag
//
//   Build option: define COMPANDER_ARB_CH0_PRIORITY_EN to give channel 0
//   strict priority; the other channels then share round-robin.
// -----------------------------------------------------------------------------
module compander_arbiter
   import compander_arb_pkg::*;
#(
   parameter int NR_CHANNELS    = 4,
   parameter int INPUT_WIDTH    = 20,
   parameter int OUTPUT_WIDTH   = 16,
   parameter int CMPNDR_LATENCY = 1,
   parameter int OUT_DEPTH      = CMPNDR_LATENCY + 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NR_CHANNELS*INPUT_WIDTH-1:0]   s_cmpndr_d,
   input  logic [NR_CHANNELS-1:0]               s_cmpndr_dv,
   output logic [NR_CHANNELS-1:0]               s_cmpndr_dr,
   output logic [INPUT_WIDTH-1:0]               c_cmpndr_d,
   output logic                                 c_cmpndr_dv,
   input  logic [OUTPUT_WIDTH-1:0]              c_cmpndr_q,
   input  logic                                 c_cmpndr_qv,
   output logic [OUTPUT_WIDTH-1:0]              m_cmpndr_d,
   output logic [ch_w(NR_CHANNELS)-1:0]         m_cmpndr_ch,
   output logic                                 m_cmpndr_dv,
   input  logic                                 m_cmpndr_dr,
   output logic                                 err
);

   localparam int CH_W  = ch_w(NR_CHANNELS);
   localparam int CNT_W = $clog2(OUT_DEPTH + 1);
   localparam int FW    = CH_W + OUTPUT_WIDTH;

   logic [INPUT_WIDTH-1:0] hold_q [NR_CHANNELS];
   logic [NR_CHANNELS-1:0] full_q;
   logic [CH_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic                   err_q;

   logic [MAX_CH-1:0]      req_ext;
   logic [MAX_CH_W-1:0]    ptr_ext;
   pick_t                  pick;
   logic                   prio_hit;
   logic                   issue_ok;
   logic                   grant_vld;
   logic [CH_W-1:0]        grant_idx;
   logic [NR_CHANNELS-1:0] grant;

   tag_t                   tag_in, tag_out;
   logic [7:0]             inflight;
   logic [CNT_W-1:0]       fifo_cnt;
   logic [FW-1:0]          fifo_din, fifo_dout;
   logic                   unused_bits;

   // ---- stage 0: arbitration and compander drive (combinational) ----
   always_comb begin
      req_ext = '0;
      req_ext[NR_CHANNELS-1:0] = full_q;
      ptr_ext = '0;
      ptr_ext[CH_W-1:0] = rr_ptr_q;
      // Credit check ignores a same-cycle pop so a result can never find the
      // FIFO full when it comes back from the compander.
      issue_ok = (int'(fifo_cnt) + int'(inflight)) < OUT_DEPTH;
      prio_hit = 1'b0;
`ifdef COMPANDER_ARB_CH0_PRIORITY_EN
      prio_hit   = full_q[0];
      req_ext[0] = 1'b0;
`endif
      pick = rr_pick(req_ext, ptr_ext, NR_CHANNELS);
      // No issue while in reset: a result for it would arrive after the tag
      // pipeline was cleared.
      grant_vld = issue_ok && !rst && (prio_hit || pick.found);
      grant_idx = prio_hit ? '0 : pick.index[CH_W-1:0];

      rr_ptr_d = rr_ptr_q;
      if (grant_vld && !prio_hit) begin
         rr_ptr_d = (grant_idx == CH_W'(NR_CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
      end

      grant      = '0;
      c_cmpndr_d = '0;
      for (int i = 0; i < NR_CHANNELS; i++) begin
         grant[i] = grant_vld && (grant_idx == CH_W'(i));
         if (grant[i]) c_cmpndr_d = hold_q[i];
      end

      tag_in = '0;
      tag_in.valid = grant_vld;
      tag_in.channel[CH_W-1:0] = grant_idx;
   end

   assign c_cmpndr_dv = grant_vld;
   // A holder being drained this cycle can accept its replacement.
   assign s_cmpndr_dr = ~full_q | grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q   <= '0;
         rr_ptr_q <= '0;
         for (int i = 0; i < NR_CHANNELS; i++) hold_q[i] <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         for (int i = 0; i < NR_CHANNELS; i++) begin
            if (s_cmpndr_dv[i] && s_cmpndr_dr[i]) begin
               hold_q[i] <= s_cmpndr_d[i*INPUT_WIDTH +: INPUT_WIDTH];
               full_q[i] <= 1'b1;
            end else if (grant[i]) begin
               full_q[i] <= 1'b0;
            end
         end
      end
   end

   // ---- stage 1..CMPNDR_LATENCY: tag pipeline matching the compander ----
   generate
      if (CMPNDR_LATENCY == 0) begin : g_tag_comb
         assign tag_out  = tag_in;
         assign inflight = '0;
      end else begin : g_tag_pipe
         tag_t tag_pipe_q [CMPNDR_LATENCY];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int s = 0; s < CMPNDR_LATENCY; s++) tag_pipe_q[s] <= '0;
            end else begin
               tag_pipe_q[0] <= tag_in;
               for (int s = 1; s < CMPNDR_LATENCY; s++) tag_pipe_q[s] <= tag_pipe_q[s-1];
            end
         end

         always_comb begin
            inflight = '0;
            for (int s = 0; s < CMPNDR_LATENCY; s++) begin
               inflight = inflight + {7'd0, tag_pipe_q[s].valid};
            end
         end

         assign tag_out = tag_pipe_q[CMPNDR_LATENCY-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (tag_out.valid != c_cmpndr_qv) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;

   // ---- result capture: output FIFO with registered head ----
   assign fifo_din = {tag_out.channel[CH_W-1:0], c_cmpndr_q};

   compander_arb_fifo #(
      .DEPTH (OUT_DEPTH),
      .WIDTH (FW),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk_i  (clk),
      .rst_i  (rst),
      .push_i (tag_out.valid),
      .din_i  (fifo_din),
      .pop_i  (m_cmpndr_dr),
      .dout_o (fifo_dout),
      .vld_o  (m_cmpndr_dv),
      .cnt_o  (fifo_cnt)
   );

   assign m_cmpndr_d  = fifo_dout[OUTPUT_WIDTH-1:0];
   assign m_cmpndr_ch = fifo_dout[FW-1:OUTPUT_WIDTH];

   // Index bits above CH_W are always zero for this configuration.
   assign unused_bits = ^{pick.index, tag_out.channel};

endmodule

// File: tb/tb_compander_arbiter.sv
module tb_compander_arbiter;

   localparam int NR    = 4;
   localparam int IW    = 20;
   localparam int OW    = 16;
   localparam int LAT   = 1;
   localparam int DEPTH = LAT + 2;

   logic              clk;
   logic              rst;
   logic [NR*IW-1:0]  s_d;
   logic [NR-1:0]     s_dv, s_dr;
   logic [IW-1:0]     c_d;
   logic              c_dv;
   logic [OW-1:0]     stub_q;
   logic              stub_qv, force_qv, c_qv;
   logic [OW-1:0]     m_d;
   logic [1:0]        m_ch;
   logic              m_dv, m_dr, err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_acc = 0;
   int n_out = 0;

   typedef struct packed {
      logic [3:0]    ch;
      logic [OW-1:0] d;
   } sb_t;
   sb_t sbq [$];
   int  out_ch_log  [$];
   int  out_cyc_log [$];
   int  hit;

   compander_arbiter #(
      .NR_CHANNELS    (NR),
      .INPUT_WIDTH    (IW),
      .OUTPUT_WIDTH   (OW),
      .CMPNDR_LATENCY (LAT),
      .OUT_DEPTH      (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_cmpndr_d  (s_d),
      .s_cmpndr_dv (s_dv),
      .s_cmpndr_dr (s_dr),
      .c_cmpndr_d  (c_d),
      .c_cmpndr_dv (c_dv),
      .c_cmpndr_q  (stub_q),
      .c_cmpndr_qv (c_qv),
      .m_cmpndr_d  (m_d),
      .m_cmpndr_ch (m_ch),
      .m_cmpndr_dv (m_dv),
      .m_cmpndr_dr (m_dr),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in compander transfer function (one-cycle registered stub).
   function automatic logic [OW-1:0] ref_cmp(input logic [IW-1:0] x);
      return {x[IW-1], x[IW-2:4]} ^ {1'b0, x[3:0], 11'h2A5};
   endfunction

   always @(posedge clk) begin
      stub_qv <= c_dv;
      stub_q  <= ref_cmp(c_d);
      cyc     <= cyc + 1;
   end

   assign c_qv = stub_qv | force_qv;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_smp(input int ch, input logic [IW-1:0] v);
      s_d[ch*IW +: IW] = v;
   endtask

   // Scoreboard: expected result queued at input acceptance, matched per
   // channel (in order) when the DUT delivers an output.
   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
      end else begin
         if (m_dv && m_dr) begin
            hit = -1;
            for (int k = 0; k < sbq.size(); k++)
               if (hit < 0 && sbq[k].ch == {2'b00, m_ch}) hit = k;
            check("sb_found", 32'(hit >= 0), 32'd1);
            if (hit >= 0) begin
               check("sb_data", 32'(m_d), 32'(sbq[hit].d));
               sbq.delete(hit);
            end
            n_out++;
            out_ch_log.push_back(int'(m_ch));
            out_cyc_log.push_back(cyc);
         end
         for (int i = 0; i < NR; i++) begin
            if (s_dv[i] && s_dr[i]) begin
               sbq.push_back({4'(i), ref_cmp(s_d[i*IW +: IW])});
               n_acc++;
            end
         end
      end
   end

   task automatic drain(input string name);
      s_dv = '0;
      for (int t = 0; t < 200 && sbq.size() != 0; t++) @(negedge clk);
      check(name, 32'(sbq.size()), 32'd0);
   endtask

   typedef struct {
      int            ch;
      logic [IW-1:0] smp;
      int            iss_t;
      int            out_t;
      logic [OW-1:0] exp_d;
   } vec_t;

   initial begin
      vec_t          vt [4];
      int            base, acc_base, out_base, iss, outt, seq;
      logic [IW-1:0] iss_d;
      logic [OW-1:0] od;
      logic [1:0]    och;
      logic [NR-1:0] acc;

      vt[0] = '{2, 20'hFFFFF, 1, 3, ref_cmp(20'hFFFFF)};
      vt[1] = '{0, 20'h00001, 1, 3, ref_cmp(20'h00001)};
      vt[2] = '{3, 20'h80000, 1, 3, ref_cmp(20'h80000)};
      vt[3] = '{1, 20'h7FFFF, 1, 3, ref_cmp(20'h7FFFF)};

      rst = 1'b1; s_dv = '0; s_d = '0; m_dr = 1'b1; force_qv = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_s_dr", 32'(s_dr), 32'hF);
      check("rst_c_dv", 32'(c_dv), 32'd0);
      check("rst_c_d", 32'(c_d), 32'd0);
      check("rst_m_dv", 32'(m_dv), 32'd0);
      check("rst_m_d", 32'(m_d), 32'd0);
      check("rst_m_ch", 32'(m_ch), 32'd0);
      check("rst_err", 32'(err), 32'd0);

      // Round-robin with all channels continuously valid.
      tick();
      base = out_ch_log.size();
      for (int i = 0; i < NR; i++) set_smp(i, 20'(32'h10000 * (i + 1)));
      s_dv = 4'hF;
      for (int t = 0; t < 100 && out_ch_log.size() < base + 12; t++) @(negedge clk);
      check("rr_count", 32'(out_ch_log.size() >= base + 12), 32'd1);
      if (out_ch_log.size() >= base + 12) begin
         for (int k = 0; k < 12; k++) check("rr_ch", 32'(out_ch_log[base+k]), 32'(k % 4));
         check("rr_rate", 32'(out_cyc_log[base+11] - out_cyc_log[base]), 32'd11);
      end
      tick();
      drain("rr_drain");
      check("rr_err", 32'(err), 32'd0);

      // Single-sample latency vectors.
      for (int v = 0; v < 4; v++) begin
         repeat (6) tick();
         set_smp(vt[v].ch, vt[v].smp);
         s_dv = NR'(1 << vt[v].ch);
         @(negedge clk);
         check("lat_ready", 32'(s_dr[vt[v].ch]), 32'd1);
         tick();
         s_dv = '0;
         iss = -1; outt = -1; iss_d = '0; od = '0; och = '0;
         for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            if (c_dv && iss < 0) begin iss = t; iss_d = c_d; end
            if (m_dv && outt < 0) begin outt = t; och = m_ch; od = m_d; end
         end
         check("lat_issue_t", 32'(iss), 32'(vt[v].iss_t));
         check("lat_issue_d", 32'(iss_d), 32'(vt[v].smp));
         check("lat_out_t", 32'(outt), 32'(vt[v].out_t));
         check("lat_out_ch", 32'(och), 32'(vt[v].ch));
         check("lat_out_d", 32'(od), 32'(vt[v].exp_d));
      end

      // Back-pressure: downstream stalled for 20 cycles.
      tick();
      seq = 1;
      m_dr = 1'b0;
      acc_base = n_acc; out_base = n_out;
      for (int i = 0; i < NR; i++) begin set_smp(i, {4'(i), 16'(seq)}); seq++; end
      s_dv = 4'hF;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         acc = s_dv & s_dr;
         tick();
         for (int i = 0; i < NR; i++) if (acc[i]) begin set_smp(i, {4'(i), 16'(seq)}); seq++; end
      end
      @(negedge clk);
      check("bp_accepted", 32'(n_acc - acc_base), 32'(NR + DEPTH));
      check("bp_no_out", 32'(n_out - out_base), 32'd0);
      check("bp_m_dv", 32'(m_dv), 32'd1);
      check("bp_stall", 32'(c_dv), 32'd0);
      check("bp_s_dr", 32'(s_dr), 32'd0);
      tick();
      m_dr = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         acc = s_dv & s_dr;
         tick();
         for (int i = 0; i < NR; i++) if (acc[i]) begin set_smp(i, {4'(i), 16'(seq)}); seq++; end
      end
      drain("bp_drain");
      check("bp_delivered", 32'(n_out - out_base), 32'(n_acc - acc_base));
      check("bp_err", 32'(err), 32'd0);

      // Forced compander fault sets a sticky error.
      tick();
      force_qv = 1'b1;
      @(negedge clk);
      check("err_before", 32'(err), 32'd0);
      tick();
      force_qv = 1'b0;
      @(negedge clk);
      check("err_rise", 32'(err), 32'd1);
      repeat (5) tick();
      @(negedge clk);
      check("err_sticky", 32'(err), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("err_clear", 32'(err), 32'd0);

      // Reset with samples in flight.
      tick();
      for (int i = 0; i < NR; i++) set_smp(i, 20'(32'hA0000 + i));
      s_dv = 4'hF;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < NR; i++) set_smp(i, 20'(32'h55550 + i));
      @(negedge clk);
      check("mid_rst_s_dr", 32'(s_dr), 32'hF);
      check("mid_rst_c_dv", 32'(c_dv), 32'd0);
      check("mid_rst_c_d", 32'(c_d), 32'd0);
      check("mid_rst_m_dv", 32'(m_dv), 32'd0);
      check("mid_rst_m_d", 32'(m_d), 32'd0);
      check("mid_rst_m_ch", 32'(m_ch), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      @(negedge clk);
      check("first_grant_dv", 32'(c_dv), 32'd1);
      check("first_grant_ch0", 32'(c_d), 32'h55550);
      tick();
      drain("mid_rst_drain");
      check("mid_rst_err_after", 32'(err), 32'd0);

`ifdef COMPANDER_ARB_CH0_PRIORITY_EN
      begin
         int pend0;
         int nz_log [$];
         tick();
         pend0 = 0;
         for (int i = 0; i < NR; i++) begin set_smp(i, {4'(i), 16'(seq)}); seq++; end
         for (int c = 0; c < 24; c++) begin
            s_dv = {3'b111, 1'(c % 2 == 0)};
            @(negedge clk);
            if (pend0 != 0) check("prio_ch0_issue", 32'(c_dv && c_d[19:16] == 4'd0), 32'd1);
            if (c_dv && c_d[19:16] != 4'd0) nz_log.push_back(int'(c_d[19:16]));
            pend0 = int'(s_dv[0] && s_dr[0]);
            acc = s_dv & s_dr;
            tick();
            for (int i = 0; i < NR; i++) if (acc[i]) begin set_smp(i, {4'(i), 16'(seq)}); seq++; end
         end
         check("prio_nz_count", 32'(nz_log.size() >= 6), 32'd1);
         for (int k = 1; k < nz_log.size(); k++)
            check("prio_rr_others", 32'(nz_log[k]), 32'((nz_log[k-1] % 3) + 1));
         drain("prio_drain");
         check("prio_err", 32'(err), 32'd0);
      end
`endif

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
